// File: rtl/sha256_pkg.sv
// Shared definitions for the hash write path: word width, address-width helper
// and the write-controller state encoding.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } hash_write_state_t;

  // Address bits needed to index n words; never less than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hash_write_ctrl_if.sv
// Digest-in / memory-write-out signal bundle for hash_write_ctrl.
// master is the controller's view; slave is the producer/memory side.
interface hash_write_ctrl_if
  import sha256_pkg::*;
#(
  parameter int HASH_LENGTH = 8
);

  localparam int AW = addr_w(HASH_LENGTH);

  logic                          hash_valid;
  logic [HASH_LENGTH*WORD_W-1:0] hash_vector;
  logic                          hash_ready;
  logic                          mem_ready;
  logic                          h_write;
  logic [AW-1:0]                 h_address;
  logic [WORD_W-1:0]             h_data;
  logic                          h_vector_complete;
  logic                          busy;

  modport master (
    input  hash_valid,
    input  hash_vector,
    input  mem_ready,
    output hash_ready,
    output h_write,
    output h_address,
    output h_data,
    output h_vector_complete,
    output busy
  );

  modport slave (
    output hash_valid,
    output hash_vector,
    output mem_ready,
    input  hash_ready,
    input  h_write,
    input  h_address,
    input  h_data,
    input  h_vector_complete,
    input  busy
  );

endinterface

// File: rtl/hash_word_sel.sv
// Selects one 32-bit word of a captured digest by index.
// HASH_WRITE_WORD_REVERSE_EN maps index i to word HASH_LENGTH-1-i (H0 in MSBs).
module hash_word_sel
  import sha256_pkg::*;
#(
  parameter int HASH_LENGTH = 8,
  parameter int AW          = addr_w(HASH_LENGTH)
) (
  input  logic [HASH_LENGTH*WORD_W-1:0] vec_i,
  input  logic [AW-1:0]                 idx_i,
  output logic [WORD_W-1:0]             word_o
);

  // Padded to a power of two so every index value has a defined slot.
  localparam int NSLOT = 1 << AW;

  logic [WORD_W-1:0] slot [NSLOT];

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    if (gi < HASH_LENGTH) begin : g_used
`ifdef HASH_WRITE_WORD_REVERSE_EN
      assign slot[gi] = vec_i[WORD_W*(HASH_LENGTH-1-gi) +: WORD_W];
`else
      assign slot[gi] = vec_i[WORD_W*gi +: WORD_W];
`endif
    end else begin : g_pad
      assign slot[gi] = '0;
    end
  end

  assign word_o = slot[idx_i];

endmodule

// File: rtl/hash_write_ctrl.sv
// Captures a digest and writes it word by word into hash memory, one word per
// accepted write. Optional build macro: HASH_WRITE_WORD_REVERSE_EN.
module hash_write_ctrl
  import sha256_pkg::*;
#(
  parameter int HASH_LENGTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  hash_write_ctrl_if.master bus
);

  localparam int            AW       = addr_w(HASH_LENGTH);
  localparam int            VW       = HASH_LENGTH * WORD_W;
  localparam logic [AW-1:0] LAST_IDX = AW'(HASH_LENGTH - 1);

  hash_write_state_t state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     buf_q, buf_d;

  logic              hash_ready_q, hash_ready_d;
  logic              h_write_q, h_write_d;
  logic [AW-1:0]     h_address_q, h_address_d;
  logic [WORD_W-1:0] h_data_q, h_data_d;
  logic              h_vc_q, h_vc_d;
  logic              busy_q, busy_d;

  logic [WORD_W-1:0] sel_word;

  // Fed from next-state values so the registered data lines up with h_write.
  hash_word_sel #(
    .HASH_LENGTH (HASH_LENGTH)
  ) u_word_sel (
    .vec_i  (buf_d),
    .idx_i  (idx_d),
    .word_o (sel_word)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (bus.hash_valid && hash_ready_q) begin
          buf_d   = bus.hash_vector;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (h_write_q && bus.mem_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    h_write_d    = (state_d == WRITE);
    h_address_d  = h_write_d ? idx_d : '0;
    h_data_d     = h_write_d ? sel_word : '0;
    h_vc_d       = (state_d == DONE);
    busy_d       = (state_d != IDLE);
    hash_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      buf_q        <= '0;
      hash_ready_q <= 1'b1;
      h_write_q    <= 1'b0;
      h_address_q  <= '0;
      h_data_q     <= '0;
      h_vc_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      hash_ready_q <= hash_ready_d;
      h_write_q    <= h_write_d;
      h_address_q  <= h_address_d;
      h_data_q     <= h_data_d;
      h_vc_q       <= h_vc_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.hash_ready        = hash_ready_q;
  assign bus.h_write           = h_write_q;
  assign bus.h_address         = h_address_q;
  assign bus.h_data            = h_data_q;
  assign bus.h_vector_complete = h_vc_q;
  assign bus.busy              = busy_q;

  a_idx_in_range : assert property (@(posedge clock) disable iff (reset)
    idx_q <= LAST_IDX);

  // A stalled write must present the same address and data until accepted.
  a_stall_hold : assert property (@(posedge clock) disable iff (reset)
    (h_write_q && !bus.mem_ready) |=>
      (h_write_q && $stable(h_address_q) && $stable(h_data_q)));

  a_complete_single : assert property (@(posedge clock) disable iff (reset)
    h_vc_q |=> !h_vc_q);

endmodule

// File: tb/tb_hash_write_ctrl.sv
// Directed bench for hash_write_ctrl: an 8-word and a 5-word instance share one
// clock; each task checks the full output tuple cycle by cycle.
module tb_hash_write_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  hash_write_ctrl_if #(.HASH_LENGTH(8)) b8 ();
  hash_write_ctrl_if #(.HASH_LENGTH(5)) b5 ();

  hash_write_ctrl #(.HASH_LENGTH(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (b8)
  );

  hash_write_ctrl #(.HASH_LENGTH(5)) dut5 (
    .clock (clock),
    .reset (reset),
    .bus   (b5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Tuple: {h_write, h_address, h_data, h_vector_complete, hash_ready, busy}
  function automatic logic [38:0] obs8();
    return {b8.h_write, b8.h_address, b8.h_data, b8.h_vector_complete, b8.hash_ready, b8.busy};
  endfunction

  function automatic logic [38:0] obs5();
    return {b5.h_write, b5.h_address, b5.h_data, b5.h_vector_complete, b5.hash_ready, b5.busy};
  endfunction

  function automatic logic [38:0] t_write(input int a, input logic [31:0] d);
    return {1'b1, 3'(a), d, 1'b0, 1'b0, 1'b1};
  endfunction

  localparam logic [38:0] T_DONE = {1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1};
  localparam logic [38:0] T_IDLE = {1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0};

  function automatic logic [255:0] mk8(input logic [31:0] base);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  function automatic logic [159:0] mk5(input logic [31:0] base);
    logic [159:0] v;
    for (int i = 0; i < 5; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] base, input int a, input int n);
`ifdef HASH_WRITE_WORD_REVERSE_EN
    return base + 32'(n - 1 - a);
`else
    if (n < 0) return 32'd0;
    return base + 32'(a);
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    b8.hash_valid  = 1'b0;
    b8.hash_vector = '0;
    b8.mem_ready   = 1'b1;
    b5.hash_valid  = 1'b0;
    b5.hash_vector = '0;
    b5.mem_ready   = 1'b1;
    tick();
    tick();
    checks++;
    if (obs8() !== T_IDLE) begin
      errors++;
      $display("FAIL reset8 got=%h exp=%h", obs8(), T_IDLE);
    end
    checks++;
    if (obs5() !== T_IDLE) begin
      errors++;
      $display("FAIL reset5 got=%h exp=%h", obs5(), T_IDLE);
    end
    reset = 1'b0;
    tick();
    $display("reset: both instances idle");
  endtask

  task automatic test_basic();
    logic [31:0] base = 32'h1000_0000;
    logic [38:0] exp;
    b8.hash_vector = mk8(base);
    b8.hash_valid  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        b8.hash_valid  = 1'b0;
        b8.hash_vector = mk8(32'hDEAD_0000);
      end
      if (c <= 8)      exp = t_write(c - 1, exp_word(base, c - 1, 8));
      else if (c == 9) exp = T_DONE;
      else             exp = T_IDLE;
      checks++;
      if (obs8() !== exp) begin
        errors++;
        $display("FAIL basic c=%0d got=%h exp=%h", c, obs8(), exp);
      end
    end
    $display("basic: digest %h written", base);
  endtask

  task automatic test_stall();
    logic [31:0] base = 32'h1000_0000;
    logic [38:0] exp;
    int a;
    b8.hash_vector = mk8(base);
    b8.hash_valid  = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) b8.hash_valid = 1'b0;
      a = (c <= 4) ? c - 1 : ((c <= 8) ? 4 : c - 4);
      if (c <= 11)      exp = t_write(a, exp_word(base, a, 8));
      else if (c == 12) exp = T_DONE;
      else              exp = T_IDLE;
      checks++;
      if (obs8() !== exp) begin
        errors++;
        $display("FAIL stall c=%0d got=%h exp=%h", c, obs8(), exp);
      end
      b8.mem_ready = !(c >= 5 && c <= 7);
    end
    b8.mem_ready = 1'b1;
    $display("stall: digest %h written with 3-cycle stall at address 4", base);
  endtask

  task automatic test_back_to_back();
    logic [31:0] base_a = 32'h2000_0000;
    logic [31:0] base_b = 32'h3000_0000;
    logic [38:0] exp;
    b8.hash_vector = mk8(base_a);
    b8.hash_valid  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1)  b8.hash_vector = mk8(base_b);
      if (c == 11) b8.hash_valid  = 1'b0;
      if (c <= 8)                 exp = t_write(c - 1, exp_word(base_a, c - 1, 8));
      else if (c == 9)            exp = T_DONE;
      else if (c == 10)           exp = T_IDLE;
      else if (c <= 18)           exp = t_write(c - 11, exp_word(base_b, c - 11, 8));
      else if (c == 19)           exp = T_DONE;
      else                        exp = T_IDLE;
      checks++;
      if (obs8() !== exp) begin
        errors++;
        $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs8(), exp);
      end
    end
    $display("back_to_back: digests %h and %h written", base_a, base_b);
  endtask

  task automatic test_reset_abort();
    logic [31:0] base = 32'h4000_0000;
    logic [31:0] base2 = 32'h5000_0000;
    logic [38:0] exp;
    int activity;
    int writes;
    int pulses;
    int next_addr;
    b8.hash_vector = mk8(base);
    b8.hash_valid  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) b8.hash_valid = 1'b0;
      exp = t_write(c - 1, exp_word(base, c - 1, 8));
      checks++;
      if (obs8() !== exp) begin
        errors++;
        $display("FAIL abort_pre c=%0d got=%h exp=%h", c, obs8(), exp);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs8() !== T_IDLE) begin
      errors++;
      $display("FAIL abort_reset got=%h exp=%h", obs8(), T_IDLE);
    end
    activity = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (b8.h_write || b8.h_vector_complete) activity++;
    end
    checks++;
    if (activity !== 0) begin
      errors++;
      $display("FAIL abort_quiet got=%0d active cycles exp=0", activity);
    end
    // Reset and a digest offer in the same cycle: reset wins.
    reset          = 1'b1;
    b8.hash_valid  = 1'b1;
    b8.hash_vector = mk8(base2);
    tick();
    checks++;
    if (obs8() !== T_IDLE) begin
      errors++;
      $display("FAIL reset_priority got=%h exp=%h", obs8(), T_IDLE);
    end
    reset = 1'b0;
    tick();
    b8.hash_valid = 1'b0;
    exp = t_write(0, exp_word(base2, 0, 8));
    checks++;
    if (obs8() !== exp) begin
      errors++;
      $display("FAIL restart_first got=%h exp=%h", obs8(), exp);
    end
    writes    = 1;
    pulses    = 0;
    next_addr = 1;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (b8.h_write) begin
        if (int'(b8.h_address) == next_addr) next_addr++;
        writes++;
      end
      if (b8.h_vector_complete) pulses++;
    end
    checks++;
    if (writes !== 8 || next_addr !== 8 || pulses !== 1) begin
      errors++;
      $display("FAIL restart_digest got=writes %0d next %0d pulses %0d exp=8 8 1", writes, next_addr, pulses);
    end
    $display("reset_abort: digest %h aborted, digest %h written", base, base2);
  endtask

  task automatic test_len5();
    logic [31:0] base = 32'h6000_0000;
    logic [38:0] exp;
    int writes;
    int pulses;
    int max_addr;
    b5.hash_vector = mk5(base);
    b5.hash_valid  = 1'b1;
    writes   = 0;
    pulses   = 0;
    max_addr = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) b5.hash_valid = 1'b0;
      if (c <= 5)      exp = t_write(c - 1, exp_word(base, c - 1, 5));
      else if (c == 6) exp = T_DONE;
      else             exp = T_IDLE;
      checks++;
      if (obs5() !== exp) begin
        errors++;
        $display("FAIL len5 c=%0d got=%h exp=%h", c, obs5(), exp);
      end
      if (b5.h_write) begin
        writes++;
        if (int'(b5.h_address) > max_addr) max_addr = int'(b5.h_address);
      end
      if (b5.h_vector_complete) pulses++;
    end
    checks++;
    if (writes !== 5 || max_addr !== 4 || pulses !== 1) begin
      errors++;
      $display("FAIL len5_totals got=writes %0d max %0d pulses %0d exp=5 4 1", writes, max_addr, pulses);
    end
    $display("len5: digest %h written", base);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_len5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_write_ctrl.md
HASH_WRITE_CTRL -- requirements
Module: hash_write_ctrl

Interface
REQ-001: Parameter HASH_LENGTH, default 8, is the number of 32-bit hash words per digest; it SHALL be >= 2.
REQ-002: Port clock, input, 1, is the single clock; all logic SHALL be clocked on its rising edge.
REQ-003: Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-004: Port hash_valid, input, 1, SHALL indicate that a digest is offered on hash_vector.
REQ-005: Port hash_vector, input, HASH_LENGTH*32, SHALL carry the digest; word i is bits [32*i+31 : 32*i].
REQ-006: Port hash_ready, output, 1, SHALL indicate that the block can accept a digest.
REQ-007: Port mem_ready, input, 1, SHALL indicate that the sink accepts the current write this cycle.
REQ-008: Port h_write, output, 1, SHALL be the write strobe to the hash memory.
REQ-009: Port h_address, output, $clog2(HASH_LENGTH), SHALL carry the word address of the current write.
REQ-010: Port h_data, output, 32, SHALL carry the word data of the current write.
REQ-011: Port h_vector_complete, output, 1, SHALL pulse once per fully written digest.
REQ-012: Port busy, output, 1, SHALL be high whenever the state is not IDLE.

Function
REQ-013: The block SHALL use an FSM with states IDLE, WRITE and DONE; all outputs SHALL be registered.
REQ-014: In IDLE, hash_ready SHALL be 1; in WRITE and DONE, hash_ready SHALL be 0.
REQ-015: When hash_valid and hash_ready are both 1, the block SHALL capture hash_vector into an internal buffer, clear the word index to 0 and enter WRITE.
REQ-016: Changes on hash_vector after capture SHALL NOT affect any written data.
REQ-017: In WRITE, h_write SHALL be 1, h_address SHALL equal the index and h_data SHALL equal buffer word[index]; h_write first rises in the cycle after capture.
REQ-018: A write SHALL complete in a cycle where h_write and mem_ready are both 1; while mem_ready is 0, h_write, h_address and h_data SHALL hold stable.
REQ-019: On a completed write with index < HASH_LENGTH-1, the index SHALL increment by 1; with index == HASH_LENGTH-1, the FSM SHALL enter DONE and h_write SHALL drop.
REQ-020: The index SHALL never exceed HASH_LENGTH-1, including for non-power-of-2 HASH_LENGTH.
REQ-021: DONE SHALL last exactly 1 cycle with h_vector_complete = 1, then return to IDLE; h_vector_complete SHALL be 0 in every other cycle.
REQ-022: With mem_ready held at 1: capture occurs in cycle 0, writes in cycles 1..HASH_LENGTH, h_vector_complete in cycle HASH_LENGTH+1, and hash_ready = 1 again in cycle HASH_LENGTH+2.
REQ-023: hash_valid while busy SHALL be ignored, and mem_ready while h_write = 0 SHALL be ignored.

Reset
REQ-024: When reset = 1, the block SHALL set state to IDLE, index = 0, h_write = 0, h_address = 0, h_data = 0, h_vector_complete = 0 and busy = 0, with hash_ready = 1 from the first cycle after reset.
REQ-025: Reset during WRITE or DONE SHALL abort the digest with no further writes and no h_vector_complete pulse, and reset SHALL take priority over hash_valid in the same cycle.

Configuration
REQ-026: Macro HASH_WRITE_WORD_REVERSE_EN, when defined, SHALL make h_data at address i equal hash_vector word HASH_LENGTH-1-i (H0 held in the MSBs).
REQ-027: When the macro is undefined, h_data at address i SHALL equal word i; addresses SHALL ascend from 0 in both cases.

Structure
REQ-028: Shared package sha256_pkg SHALL hold the WORD_W = 32 constant and the hash_write_state_t enum (IDLE, WRITE, DONE).
REQ-029: The word-select multiplexer, including the reversal option, SHALL be the single sub-module hash_word_sel; the FSM, index counter and buffer SHALL stay in the top.

Verification
REQ-030: HASH_LENGTH=8, mem_ready=1, word i = 32'h1000_0000+i -> writes at addresses 0..7 in cycles 1..8 with data 1000_0000..1000_0007, h_vector_complete in cycle 9 only.
REQ-031: mem_ready low for 3 cycles at address 4 -> address 4 and data 1000_0004 held for 4 cycles; total digest time +3 cycles; no skipped or duplicated address.
REQ-032: Second hash_valid held through a digest with a different vector -> ignored until IDLE; the second digest starts only after hash_ready rises, and its data matches the second vector.
REQ-033: reset asserted in the cycle of the write to address 5 -> h_write=0 next cycle, no h_vector_complete, hash_ready=1, and a subsequent digest writes from address 0.
REQ-034: HASH_WRITE_WORD_REVERSE_EN defined, same vector as REQ-030 -> address 0 carries 1000_0007 and address 7 carries 1000_0000.
REQ-035: HASH_LENGTH=5 -> exactly 5 writes at addresses 0..4, the index never reaches 5, and h_vector_complete is a single pulse.
